// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle CPU: holds CPU reset after a start, then runs a bounded or unbounded
// number of enabled cycles. Define CPU_RUN_CTRL_STEP_EN to enable single-step execution via Step_Mode/Step.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt_Req,
    input  logic             Step_Mode,
    input  logic             Step,
    output logic             Cpu_Reset,
    output logic             Cpu_En,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic             Running,
    output logic             Done
);

    typedef enum logic [1:0] {S_IDLE, S_RST_HOLD, S_RUN, S_DONE} state_t;

    localparam logic [7:0]       HOLD_INIT = 8'(RESET_CYCLES);
    localparam logic [CNT_W:0]   LIMIT     = (CNT_W+1)'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           r_state;
    logic [7:0]       r_hold;
    logic             w_run_en;
    logic             w_limit;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef CPU_RUN_CTRL_STEP_EN
    logic r_step_d;
    logic w_step_rise;

    always_ff @(posedge Clk) begin
        if (!Reset) r_step_d <= 1'b0;
        else        r_step_d <= Step;
    end

    assign w_step_rise = Step & ~r_step_d;
    assign w_run_en    = ~Step_Mode | w_step_rise;
`else
    logic w_unused_step;
    assign w_unused_step = Step_Mode ^ Step;
    assign w_run_en      = 1'b1;
`endif

    // Counter saturates rather than wrapping so an unlimited run never reads as a short one.
    assign w_cnt_next = (Cycle_Count == CNT_MAX) ? Cycle_Count : Cycle_Count + CNT_W'(1);
    assign w_limit    = (MAX_CYCLES != 0) && Cpu_En && (({1'b0, Cycle_Count} + (CNT_W+1)'(1)) == LIMIT);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            Cpu_Reset   <= 1'b0;
            Cpu_En      <= 1'b0;
            Cycle_Count <= '0;
            Running     <= 1'b0;
            Done        <= 1'b0;
        end else begin
            if (Cpu_En) Cycle_Count <= w_cnt_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state     <= S_RST_HOLD;
                        r_hold      <= HOLD_INIT;
                        Cpu_Reset   <= 1'b0;
                        Cycle_Count <= '0;
                        Done        <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    Cycle_Count <= '0;
                    if (r_hold <= 8'd1) begin
                        r_state   <= S_RUN;
                        Cpu_Reset <= 1'b1;
                        Running   <= 1'b1;
                        Cpu_En    <= w_run_en;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end
                S_RUN: begin
                    // The final enabled cycle is still counted by the increment above.
                    if (Halt_Req || w_limit) begin
                        r_state <= S_DONE;
                        Cpu_En  <= 1'b0;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else begin
                        Cpu_En <= w_run_en;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (bounded and unlimited/narrow counter) against a timeline model.
module tb_cpu_run_ctrl;

    localparam int RC0 = 2, MX0 = 5, CW0 = 16;
    localparam int RC1 = 3, MX1 = 0, CW1 = 4;

    logic clk = 1'b0;
    logic Reset = 1'b0, Start = 1'b0, Halt_Req = 1'b0, Step_Mode = 1'b0, Step = 1'b0;
    logic d0_rst, d0_en, d0_running, d0_done;
    logic d1_rst, d1_en, d1_running, d1_done;
    logic [CW0-1:0] d0_cnt;
    logic [CW1-1:0] d1_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RESET_CYCLES(RC0), .MAX_CYCLES(MX0), .CNT_W(CW0)) dut0 (
        .Clk(clk), .Reset(Reset), .Start(Start), .Halt_Req(Halt_Req), .Step_Mode(Step_Mode), .Step(Step),
        .Cpu_Reset(d0_rst), .Cpu_En(d0_en), .Cycle_Count(d0_cnt), .Running(d0_running), .Done(d0_done));

    cpu_run_ctrl #(.RESET_CYCLES(RC1), .MAX_CYCLES(MX1), .CNT_W(CW1)) dut1 (
        .Clk(clk), .Reset(Reset), .Start(Start), .Halt_Req(Halt_Req), .Step_Mode(Step_Mode), .Step(Step),
        .Cpu_Reset(d1_rst), .Cpu_En(d1_en), .Cycle_Count(d1_cnt), .Running(d1_running), .Done(d1_done));

    // Timeline model: a run is described by the edge at which Start was taken and whether it has stopped.
    int edge_no = 0;
    bit m_started[2], m_stopped[2], m_en[2], m_rst[2], m_running[2], m_done[2];
    int m_tstart[2], m_cnt[2];
    bit m_step_prev = 1'b0;

    always @(posedge clk) begin : model
        bit rise;
        rise = Step && !m_step_prev;
        for (int i = 0; i < 2; i++) begin : inst
            bit was_run, run_now;
            int rc, mx, cmax;
            rc   = (i == 0) ? RC0 : RC1;
            mx   = (i == 0) ? MX0 : MX1;
            cmax = (1 << ((i == 0) ? CW0 : CW1)) - 1;
            if (!Reset) begin
                m_started[i] = 0; m_stopped[i] = 0; m_cnt[i] = 0; m_en[i] = 0;
            end else begin
                was_run = m_started[i] && !m_stopped[i] && (edge_no - 1 >= m_tstart[i] + rc);
                if (m_en[i]) m_cnt[i] = (m_cnt[i] < cmax) ? m_cnt[i] + 1 : cmax;
                if ((!m_started[i] || m_stopped[i]) && Start) begin
                    m_started[i] = 1; m_stopped[i] = 0; m_tstart[i] = edge_no; m_cnt[i] = 0;
                end else if (was_run && (Halt_Req || (mx != 0 && m_en[i] && m_cnt[i] == mx))) begin
                    m_stopped[i] = 1;
                end
                run_now = m_started[i] && !m_stopped[i] && (edge_no >= m_tstart[i] + rc);
`ifdef CPU_RUN_CTRL_STEP_EN
                m_en[i] = run_now && (!Step_Mode || rise);
`else
                m_en[i] = run_now;
`endif
            end
            run_now      = m_started[i] && !m_stopped[i] && (edge_no >= m_tstart[i] + rc);
            m_running[i] = Reset && run_now;
            m_done[i]    = Reset && m_started[i] && m_stopped[i];
            m_rst[i]     = Reset && m_started[i] && (m_stopped[i] || run_now);
        end
        m_step_prev = Reset ? Step : 1'b0;
        edge_no++;
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: actual %0d required %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m0_cpu_reset", d0_rst, m_rst[0]);
            check("m0_cpu_en", d0_en, m_en[0]);
            check("m0_count", int'(d0_cnt), m_cnt[0]);
            check("m0_running", d0_running, m_running[0]);
            check("m0_done", d0_done, m_done[0]);
            check("m1_cpu_reset", d1_rst, m_rst[1]);
            check("m1_cpu_en", d1_en, m_en[1]);
            check("m1_count", int'(d1_cnt), m_cnt[1]);
            check("m1_running", d1_running, m_running[1]);
            check("m1_done", d1_done, m_done[1]);
        end
    end

    task automatic start_pulse();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_cnt0(int target);
        int n = 0;
        while (int'(d0_cnt) != target && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_count0", int'(d0_cnt), target);
    endtask

    // Hand-computed bounded run for RESET_CYCLES=2, MAX_CYCLES=5; sample j follows edge j.
    task automatic bounded_seq();
        Start = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            Start = 1'b0;
            check("lit_cpu_reset", d0_rst, (j >= 2) ? 1 : 0);
            check("lit_cpu_en", d0_en, (j >= 2 && j <= 6) ? 1 : 0);
            check("lit_done", d0_done, (j >= 7) ? 1 : 0);
            check("lit_count", int'(d0_cnt), (j < 2) ? 0 : ((j - 2 < 5) ? j - 2 : 5));
        end
    endtask

`ifdef CPU_RUN_CTRL_STEP_EN
    bit pat [12] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0};
`endif

    initial begin
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        chk_on = 1'b1;
        check("rst_cpu_reset", d0_rst, 0);
        check("rst_cpu_en", d0_en, 0);
        check("rst_count", int'(d0_cnt), 0);
        check("rst_done", d0_done, 0);
        check("rst_count1", int'(d1_cnt), 0);

        bounded_seq();
        bounded_seq();

        start_pulse();
        wait_cnt0(2);
        Halt_Req = 1'b1;
        @(negedge clk);
        Halt_Req = 1'b0;
        check("halt_cpu_en", d0_en, 0);
        check("halt_done", d0_done, 1);
        check("halt_count", int'(d0_cnt), 3);

        start_pulse();
        wait_cnt0(3);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        check("midrst_cpu_reset", d0_rst, 0);
        check("midrst_cpu_en", d0_en, 0);
        check("midrst_count", int'(d0_cnt), 0);
        check("midrst_running", d0_running, 0);
        check("midrst_done", d0_done, 0);

        start_pulse();
        repeat (RC1 + 20) @(negedge clk);
        check("sat_count", int'(d1_cnt), 15);
        check("sat_running", d1_running, 1);
        check("sat_done", d1_done, 0);

`ifdef CPU_RUN_CTRL_STEP_EN
        begin
            int n = 0;
            int pulses = 0;
            Halt_Req = 1'b1;
            @(negedge clk);
            Halt_Req = 1'b0;
            Step_Mode = 1'b1;
            Step = 1'b0;
            start_pulse();
            while (!d0_running && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("step_running", d0_running, 1);
            for (int k = 0; k < 12; k++) begin
                Step = pat[k];
                @(negedge clk);
                pulses += int'(d0_en);
            end
            check("step_pulses", pulses, 3);
            check("step_count", int'(d0_cnt), 3);
            Step_Mode = 1'b0;
        end
`endif

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            Reset     = ($urandom % 64) != 0;
            Start     = ($urandom % 8) == 0;
            Halt_Req  = ($urandom % 16) == 0;
            Step      = $urandom % 2;
            if (($urandom % 16) == 0) Step_Mode = ~Step_Mode;
        end
        Reset = 1'b1;
        Start = 1'b0;
        Halt_Req = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable, parametrised run controller for the single-cycle CPU. It replaces hand-timed reset and clock stimulus with a sequencer, and sits between the board/bench and the CPU's reset and enable inputs. On a start request it holds the CPU in reset for a programmable number of cycles, then runs it for a bounded or unbounded number of enabled cycles. It supports early halt and, optionally, single-step execution, and exposes a cycle counter and done flag for the bench or debug logic.

## Interface
- `RESET_CYCLES`, default 2: cycles the CPU reset is held low after a start; legal range 1..255.
- `MAX_CYCLES`, default 16: enabled CPU cycles before automatic stop; 0 means unlimited.
- `CNT_W`, default 16: width of the cycle counter.
- `Clk`  in  1  sole clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  level; sampled in IDLE or DONE to begin a run.
- `Halt_Req`  in  1  level; sampled in RUN to stop early.
- `Step_Mode`  in  1  selects single-step execution (see Configuration).
- `Step`  in  1  step request; its rising edge is detected internally.
- `Cpu_Reset`  out  1  active-low reset to the CPU.
- `Cpu_En`  out  1  CPU clock-enable (PC/regfile/memory write enable).
- `Cycle_Count`  out  CNT_W  number of cycles in which `Cpu_En` was 1 during the current run.
- `Running`  out  1  high in RUN.
- `Done`  out  1  high in DONE.

## Operation
- States: IDLE, RST_HOLD, RUN, DONE. All outputs are registered.
- Reset low, at any time including mid-run:
  - state goes to IDLE;
  - `Cpu_Reset`=0, `Cpu_En`=0, `Cycle_Count`=0, `Running`=0, `Done`=0;
  - the step edge detector is cleared.
- IDLE: `Cpu_Reset`=0. `Start`=1 moves to RST_HOLD and loads the hold counter with `RESET_CYCLES`.
- RST_HOLD: `Cpu_Reset`=0 and `Cycle_Count` is cleared. The hold counter decrements each cycle; at 1 the next state is RUN.
- RUN:
  - `Cpu_Reset`=1, `Running`=1.
  - `Cpu_En`=1 every cycle, unless step mode is active.
  - `Cycle_Count` increments on every cycle with `Cpu_En`=1.
  - The controller moves to DONE on the cycle after the enabled cycle that makes `Cycle_Count` equal `MAX_CYCLES` (only when `MAX_CYCLES`≠0).
  - With `MAX_CYCLES`=0, the counter saturates at all-ones instead of wrapping, and the run continues until halted.
- `Halt_Req`=1 in RUN moves to DONE. `Cpu_En` is 0 from the next cycle, and no further count increments occur.
- If halt and the limit fall on the same cycle: go to DONE, and the count includes that final enabled cycle.
- DONE: `Done`=1, `Cpu_En`=0, `Cpu_Reset`=1 (CPU state preserved for inspection), and `Cycle_Count` is held. `Start`=1 re-enters RST_HOLD.
- `Start` is ignored in RST_HOLD and RUN.

## Timing
- Start to reset hold: `Start` sampled at edge k gives `Cpu_Reset`=0 for cycles k+1 .. k+`RESET_CYCLES`.
- First enabled cycle: `Cpu_Reset`=1 and `Cpu_En`=1 from cycle k+`RESET_CYCLES`+1.
- `Cycle_Count` updates on the edge ending each enabled cycle.
- Automatic stop: `Done` rises on the cycle immediately after the `MAX_CYCLES`-th enabled cycle. At that point `Cpu_En` is already 0.
- Halt latency: `Halt_Req` sampled at edge h gives `Cpu_En`=0 and `Done`=1 from cycle h+1.
- Step latency: a `Step` rising edge detected at edge s produces exactly one `Cpu_En`=1 cycle at s+1.

## Configuration
- Macro: `CPU_RUN_CTRL_STEP_EN`.
- Defined:
  - In RUN with `Step_Mode`=1, `Cpu_En` is 0 except for a single-cycle pulse per `Step` rising edge.
  - A `Step` held high gives one pulse only.
  - Steps still count toward `MAX_CYCLES`.
  - Toggling `Step_Mode` mid-run takes effect on the next cycle.
- Not defined: `Step_Mode` and `Step` are ignored (ports remain), and RUN always asserts `Cpu_En`.

## Test plan
- **Reset mid-run.** Run with `RESET_CYCLES`=2, `MAX_CYCLES`=5. Pull `Reset` low during RUN at `Cycle_Count`=3. Required: next cycle shows IDLE, `Cpu_Reset`=0, `Cpu_En`=0, `Cycle_Count`=0, `Done`=0.
- **Bounded run.** With `RESET_CYCLES`=2, `MAX_CYCLES`=5, pulse `Start` at edge 0. Required: `Cpu_Reset` low in cycles 1–2, `Cpu_En` high in cycles 3–7, `Done`=1 at cycle 8, `Cycle_Count`=5.
- **Early halt.** Assert `Halt_Req` with `Cycle_Count`=2. Required: next cycle `Cpu_En`=0, `Done`=1, `Cycle_Count`=3.
- **Unlimited saturation.** With `MAX_CYCLES`=0, `CNT_W`=4, run 20 cycles. Required: `Cycle_Count` saturates at 15, `Running` stays 1, `Done`=0.
- **Single step** (macro defined). Set `Step_Mode`=1 in RUN and hold `Step` high for 4 cycles, then apply 2 more rising edges. Required: exactly 3 `Cpu_En` pulses, `Cycle_Count`=3.
- **Restart.** In DONE with `Cycle_Count`=5, pulse `Start`. Required: count clears in RST_HOLD and the full sequence repeats identically.
